// File: rtl/spad_pixel_packer_if.sv
// -----------------------------------------------------------------------------
// spad_pixel_packer_if
// Bundles the SPAD manager beat bus and the packed-word stream into one
// interface.
//   Beat side   : ReadEnable, PixelIn0..PixelIn3, RowSelect, ColSelect, RowGroup
//   Stream side : TData, TValid, TReady, TLast, TUser
// Modports:
//   master : environment view (drives beats, consumes the stream)
//   slave  : packer view (receives beats, produces the stream)
// -----------------------------------------------------------------------------
interface spad_pixel_packer_if;
   logic        ReadEnable;
   logic [7:0]  PixelIn0;
   logic [7:0]  PixelIn1;
   logic [7:0]  PixelIn2;
   logic [7:0]  PixelIn3;
   logic [2:0]  RowSelect;
   logic [5:0]  ColSelect;
   logic        RowGroup;
   logic [63:0] TData;
   logic        TValid;
   logic        TReady;
   logic        TLast;
   logic        TUser;

   modport master (
      output ReadEnable, PixelIn0, PixelIn1, PixelIn2, PixelIn3,
             RowSelect, ColSelect, RowGroup, TReady,
      input  TData, TValid, TLast, TUser
   );

   modport slave (
      input  ReadEnable, PixelIn0, PixelIn1, PixelIn2, PixelIn3,
             RowSelect, ColSelect, RowGroup, TReady,
      output TData, TValid, TLast, TUser
   );
endinterface

// File: rtl/spad_pixel_packer.sv
// -----------------------------------------------------------------------------
// spad_pixel_packer
// Pairs consecutive 32-bit SPAD pixel beats into 64-bit words (even beat in
// the low half) and queues them in a 4-entry output FIFO with TValid/TReady.
// A frame is 1024 beats starting at RowGroup=0/RowSelect=0/ColSelect=0.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous, active-high
//   bus          : spad_pixel_packer_if.slave (beat input + word stream output)
//   DropCount    : saturating count of words lost to a full FIFO
//   SyncErrCount : saturating count of half-words discarded by a start beat
// Optional feature: define SPAD_PACKER_HEADER_EN to push a frame header word
// {16'hA5A5, 16'h0000, frame counter} (TUser=1) on every start beat.
// -----------------------------------------------------------------------------
module spad_pixel_packer (
   input  logic                      clk,
   input  logic                      reset,
   spad_pixel_packer_if.slave        bus,
   output logic [15:0]               DropCount,
   output logic [15:0]               SyncErrCount
);

`ifdef SPAD_PACKER_HEADER_EN
   localparam logic HDR_EN = 1'b1;
`else
   localparam logic HDR_EN = 1'b0;
`endif

   localparam int DEPTH = 4;

   function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
      logic [16:0] s;
      s = {1'b0, a} + {15'd0, inc};
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

   logic [31:0] beat;
   logic        start_beat;
   logic        last_beat;
   logic        even_beat;
   logic        odd_beat;

   logic        running;
   logic        pend_vld;
   logic        pend_first;
   logic [31:0] pend_data;
   logic [31:0] frame_cnt;

   logic        vld_p0;
   logic [63:0] data_p0;
   logic        last_p0;
   logic        user_p0;

   logic [65:0] mem [DEPTH];
   logic [2:0]  count;
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;

   logic        pop;
   logic        push_a;
   logic        push_b;
   logic        acc_a;
   logic        acc_b;
   logic [2:0]  room;
   logic [1:0]  drops;
   logic [63:0] hdr_word;

   assign beat       = {bus.PixelIn3, bus.PixelIn2, bus.PixelIn1, bus.PixelIn0};
   assign start_beat = bus.ReadEnable && !bus.RowGroup &&
                       (bus.RowSelect == 3'd0) && (bus.ColSelect == 6'd0);
   assign last_beat  = bus.RowGroup && (&bus.RowSelect) && (&bus.ColSelect);
   // pend_vld can only be set once a start beat has been seen, so it
   // alone decides the beat's parity inside a running frame.
   assign even_beat  = bus.ReadEnable && !start_beat && running && !pend_vld;
   assign odd_beat   = bus.ReadEnable && !start_beat && running && pend_vld;

   // Header carries the post-increment frame number.
   assign hdr_word   = {16'hA5A5, 16'h0000, frame_cnt + 32'd1};

   // Two pushes can land in one cycle: the staged pixel word from the previous
   // frame's last beat and the header of a start beat. The pixel word goes first.
   always_comb begin
      pop    = (count != 3'd0) && bus.TReady;
      push_a = vld_p0;
      push_b = HDR_EN && start_beat;
      room   = 3'(DEPTH) - count + {2'b00, pop};
      acc_a  = push_a && (room != 3'd0);
      acc_b  = push_b && (room > {2'b00, acc_a});
      drops  = {1'b0, push_a && !acc_a} + {1'b0, push_b && !acc_b};
   end

   // Control state: frame tracking, stage valid, FIFO pointers, counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running      <= 1'b0;
         pend_vld     <= 1'b0;
         frame_cnt    <= 32'd0;
         vld_p0       <= 1'b0;
         count        <= 3'd0;
         wr_ptr       <= 2'd0;
         rd_ptr       <= 2'd0;
         DropCount    <= 16'd0;
         SyncErrCount <= 16'd0;
      end else begin
         vld_p0 <= odd_beat;
         if (start_beat) begin
            running   <= 1'b1;
            pend_vld  <= 1'b1;
            frame_cnt <= frame_cnt + 32'd1;
            if (pend_vld)
               SyncErrCount <= sat_add16(SyncErrCount, 2'd1);
         end else if (even_beat) begin
            pend_vld <= 1'b1;
         end else if (odd_beat) begin
            pend_vld <= 1'b0;
         end
         count     <= count + {2'b00, acc_a} + {2'b00, acc_b} - {2'b00, pop};
         wr_ptr    <= wr_ptr + {1'b0, acc_a} + {1'b0, acc_b};
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         DropCount <= sat_add16(DropCount, drops);
      end
   end

   // Data path: pending half, p0 word stage, FIFO storage (no reset needed,
   // everything here is qualified by a control valid).
   always_ff @(posedge clk) begin
      if (start_beat || even_beat) begin
         pend_data  <= beat;
         pend_first <= start_beat;
      end
      if (odd_beat) begin
         data_p0 <= {beat, pend_data};
         last_p0 <= last_beat;
         user_p0 <= pend_first && !HDR_EN;
      end
      if (acc_a)
         mem[wr_ptr] <= {data_p0, last_p0, user_p0};
      if (acc_b)
         mem[wr_ptr + {1'b0, acc_a}] <= {hdr_word, 1'b0, 1'b1};
   end

   // Outputs read straight from the FIFO head, forced to zero when empty.
   assign bus.TValid = (count != 3'd0);
   assign {bus.TData, bus.TLast, bus.TUser} = bus.TValid ? mem[rd_ptr] : 66'd0;

endmodule

// File: tb/tb_spad_pixel_packer.sv
module tb_spad_pixel_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] DropCount;
   logic [15:0] SyncErrCount;

   spad_pixel_packer_if bus();

   spad_pixel_packer dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .DropCount    (DropCount),
      .SyncErrCount (SyncErrCount)
   );

   always #5 clk = ~clk;

`ifdef SPAD_PACKER_HEADER_EN
   localparam logic FU       = 1'b0;  // TUser of first pixel word
   localparam int   KEEP     = 3;     // pixel words held when stalled
   localparam int   EXP_DROP = 3;
`else
   localparam logic FU       = 1'b1;
   localparam int   KEEP     = 4;
   localparam int   EXP_DROP = 2;
`endif

   typedef struct {
      logic [63:0] d;
      logic        l;
      logic        u;
   } exp_t;

   exp_t        sbq[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] hdr_frame = 32'd0;

   task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [63:0] d, input logic l, input logic u);
      exp_t e;
      e.d = d;
      e.l = l;
      e.u = u;
      sbq.push_back(e);
   endtask

   // Header expectation for a start beat that will be accepted.
   task automatic exp_start();
`ifdef SPAD_PACKER_HEADER_EN
      hdr_frame = hdr_frame + 32'd1;
      push_exp({16'hA5A5, 16'h0000, hdr_frame}, 1'b0, 1'b1);
`endif
   endtask

   task automatic drive_beat(input int idx, input logic [31:0] v);
      logic [9:0] c;
      c = idx[9:0];
      @(posedge clk);
      #1;
      bus.ReadEnable = 1'b1;
      bus.RowGroup   = c[9];
      bus.RowSelect  = c[8:6];
      bus.ColSelect  = c[5:0];
      bus.PixelIn0   = v[7:0];
      bus.PixelIn1   = v[15:8];
      bus.PixelIn2   = v[23:16];
      bus.PixelIn3   = v[31:24];
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         bus.ReadEnable = 1'b0;
      end
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      total++;
      assert (sbq.size() == 0) else begin
         bad++;
         $error("FAIL %s observed=%0d_pending expected=0_pending", tag, sbq.size());
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      reset = 1'b1;
      sbq.delete();
      hdr_frame = 32'd0;
   endtask

   // Scoreboard consumer: a word transfers on the next rising edge.
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.TValid === 1'b1 && bus.TReady === 1'b1) begin
         total++;
         assert (sbq.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_word observed=%h expected=no_word", bus.TData);
         end
         if (sbq.size() != 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("word", {bus.TData, bus.TLast, bus.TUser}, {e.d, e.l, e.u});
         end
      end
   end

   initial begin
      exp_t h;
      reset          = 1'b1;
      bus.ReadEnable = 1'b0;
      bus.RowGroup   = 1'b0;
      bus.RowSelect  = 3'd0;
      bus.ColSelect  = 6'd0;
      bus.PixelIn0   = 8'd0;
      bus.PixelIn1   = 8'd0;
      bus.PixelIn2   = 8'd0;
      bus.PixelIn3   = 8'd0;
      bus.TReady     = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // Reset state
      chk("rst_tvalid", 66'(bus.TValid), 66'(0));
      chk("rst_tdata",  66'(bus.TData),  66'(0));
      chk("rst_tlast",  66'(bus.TLast),  66'(0));
      chk("rst_tuser",  66'(bus.TUser),  66'(0));
      chk("rst_drop",   66'(DropCount),  66'(0));
      chk("rst_sync",   66'(SyncErrCount), 66'(0));
      @(negedge clk);
      reset = 1'b0;

      // Beats before any start beat are ignored
      for (int i = 5; i < 9; i++) drive_beat(i, 32'hDEAD_0000 + 32'(i));
      idle(4);
      chk("prestart_tvalid", 66'(bus.TValid), 66'(0));
      chk("prestart_sync",   66'(SyncErrCount), 66'(0));

      // Full frame, beat value = beat index
      exp_start();
      for (int i = 0; i < 1024; i++) begin
         drive_beat(i, 32'(i));
         if (i % 2 == 1)
            push_exp({32'(i), 32'(i - 1)}, (i == 1023), (i == 1) ? FU : 1'b0);
      end
      idle(1);
      wait_drain("frame_drain", 50);
      chk("frame_drop", 66'(DropCount), 66'(0));
      chk("frame_sync", 66'(SyncErrCount), 66'(0));

      // Start beat while an even half is pending
      idle(2);
      exp_start();
      drive_beat(0, 32'hA0A0_0000);
      drive_beat(1, 32'hA1A1_0001);
      push_exp({32'hA1A1_0001, 32'hA0A0_0000}, 1'b0, FU);
      drive_beat(2, 32'hA2A2_0002);
      exp_start();
      drive_beat(0, 32'hB0B0_0000);
      drive_beat(1, 32'hB1B1_0001);
      push_exp({32'hB1B1_0001, 32'hB0B0_0000}, 1'b0, FU);
      idle(2);
      wait_drain("sync_drain", 20);
      chk("sync_err", 66'(SyncErrCount), 66'(1));

      // Backpressure: six words into a four-entry FIFO
      bus.TReady = 1'b0;
      do_reset();
      @(negedge clk);
      reset = 1'b0;
      exp_start();
      for (int i = 0; i < 12; i++) begin
         drive_beat(i, 32'h5000_0000 + 32'(i));
         if (i % 2 == 1 && (i - 1) / 2 < KEEP)
            push_exp({32'h5000_0000 + 32'(i), 32'h5000_0000 + 32'(i - 1)}, 1'b0,
                     (i == 1) ? FU : 1'b0);
      end
      idle(3);
      h = sbq[0];
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stall_tvalid", 66'(bus.TValid), 66'(1));
         chk("stall_head", {bus.TData, bus.TLast, bus.TUser}, {h.d, h.l, h.u});
      end
      chk("stall_drop", 66'(DropCount), 66'(EXP_DROP));

      // Drop counter saturation
      @(negedge clk);
      force dut.DropCount = 16'hFFFE;
      #1;
      release dut.DropCount;
      drive_beat(12, 32'h5000_000C);
      drive_beat(13, 32'h5000_000D);
      idle(3);
      chk("sat_first", 66'(DropCount), 66'(16'hFFFF));
      for (int i = 14; i < 18; i++) drive_beat(i, 32'h5000_0000 + 32'(i));
      idle(3);
      chk("sat_hold", 66'(DropCount), 66'(16'hFFFF));
      bus.TReady = 1'b1;
      wait_drain("stall_drain", 20);

      // Asynchronous reset in the middle of a word
      bus.TReady = 1'b0;
      drive_beat(0, 32'hC0C0_0000);
      drive_beat(1, 32'hC1C1_0001);
      drive_beat(2, 32'hC2C2_0002);
      idle(1);
      chk("prerst_tvalid", 66'(bus.TValid), 66'(1));
      do_reset();
      #1;
      chk("arst_tvalid", 66'(bus.TValid), 66'(0));
      chk("arst_tdata",  66'(bus.TData),  66'(0));
      chk("arst_tuser",  66'(bus.TUser),  66'(0));
      chk("arst_drop",   66'(DropCount),  66'(0));
      chk("arst_sync",   66'(SyncErrCount), 66'(0));
      @(negedge clk);
      reset = 1'b0;
      bus.TReady = 1'b1;
      for (int i = 3; i < 7; i++) drive_beat(i, 32'hD0D0_0000 + 32'(i));
      idle(4);
      chk("postrst_tvalid", 66'(bus.TValid), 66'(0));
      exp_start();
      drive_beat(0, 32'hE0E0_0000);
      drive_beat(1, 32'hE1E1_0001);
      push_exp({32'hE1E1_0001, 32'hE0E0_0000}, 1'b0, FU);
      idle(2);
      wait_drain("postrst_drain", 20);
      chk("postrst_drop", 66'(DropCount), 66'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spad_pixel_packer.md
SPAD_PIXEL_PACKER -- requirements
Module: spad_pixel_packer

Interface
REQ-001 clk  in  1  sole clock; all logic rising-edge.
REQ-002 reset  in  1  asynchronous, active-high; clears all state.
REQ-003 ReadEnable  in  1  pixel beat valid, from the SPAD manager, one beat per asserted cycle, no backpressure.
REQ-004 PixelIn0..PixelIn3  in  8 each  pixel values of the current beat.
REQ-005 RowSelect  in  3 / ColSelect  in  6 / RowGroup  in  1  beat coordinates, sampled with ReadEnable.
REQ-006 TData  out  64  packed word; TValid out 1; TReady in 1; TLast out 1 (last word of frame); TUser out 1 (first word of frame).
REQ-007 DropCount  out  16  saturating count of words lost to FIFO full.
REQ-008 SyncErrCount  out  16  saturating count of discarded half-words.

Function
REQ-009 Beat value B = {PixelIn3,PixelIn2,PixelIn1,PixelIn0}; word = {B_odd, B_even}, even beat in bits 31:0.
REQ-010 Frame = 1024 beats (RowGroup 0..1, RowSelect 0..7, ColSelect 0..63, ColSelect fastest) = 512 pixel words.
REQ-011 Start beat: ReadEnable with RowGroup=0, RowSelect=0, ColSelect=0; always begins a new frame and is an even beat.
REQ-012 Start beat while an even half is pending: pending half discarded, SyncErrCount +1.
REQ-013 Pixel word pushed into FIFO on the cycle after its odd beat is sampled (1-cycle latency to FIFO write).
REQ-014 Word containing the beat RowGroup=1, RowSelect=7, ColSelect=63 carries TLast=1; any other word TLast=0.
REQ-015 Output FIFO depth 4 words, each entry {TData,TLast,TUser}; TValid=1 whenever non-empty; head pops on TValid&TReady.
REQ-016 Simultaneous push and pop while full: push accepted, no drop.
REQ-017 Push while full without pop: word dropped, DropCount +1 (saturate at 16'hFFFF), FIFO unchanged.
REQ-018 TData/TLast/TUser stable while TValid=1 and TReady=0.
REQ-019 Beats before the first start beat after reset are ignored, not counted.
REQ-020 Frame counter, 32 bits, increments at each start beat, wraps 32'hFFFFFFFF->0.

Reset
REQ-021 On reset: TValid=0, TData=0, TLast=0, TUser=0, DropCount=0, SyncErrCount=0, FIFO empty, pending half cleared, frame counter=0, state=waiting-for-start.
REQ-022 Reset mid-frame: partial word and FIFO contents lost; next data accepted only from a start beat.

Configuration
REQ-023 Macro SPAD_PACKER_HEADER_EN defined: on each start beat a header word {16'hA5A5, 16'h0000, frame counter post-increment} is pushed in the same cycle the start beat is sampled, TUser=1, TLast=0; first pixel word TUser=0.
REQ-024 Macro undefined: no header; first pixel word of frame TUser=1; frame counter still maintained internally.
REQ-025 Header push obeys REQ-016/017 drop rules; dropped header counts in DropCount.

Verification
REQ-026 Full frame, TReady=1, macro off: 1024 beats PixelIn0..3=beat index bytes -> 512 words, word0 TUser=1, word511 TLast=1, DropCount=0.
REQ-027 Macro on, two frames: header words TData[31:0]=1 then 2, TData[63:48]=16'hA5A5, TUser=1 only on headers.
REQ-028 TReady=0, 6 consecutive pixel words -> FIFO holds 4, DropCount=2, TData of head unchanged until TReady=1.
REQ-029 Start beat issued after one odd-aligned beat mid-frame -> SyncErrCount=1, next word = {beat1,start beat}.
REQ-030 Reset asserted asynchronously mid-word -> outputs 0 immediately; beats before next start beat produce no words.
REQ-031 Force DropCount to 16'hFFFE via 3 more drops -> holds 16'hFFFF.
